cp0_unit: RTL
=============

# cp0_unit

Coprocessor-0 register block for the 5-stage MIPS pipeline. It takes the exception record produced by the execute stage (bad virtual address, EPC, Cause.BD/ExcCode), latches it into the architectural CP0 registers, and raises the redirect to the exception vector. It also serves `mfc0`/`mtc0`/`eret`, samples hardware interrupt lines, runs the Count/Compare timer, and drives the pending-interrupt request back to the pipeline.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: redirect PC on exception.
- `clk` input 1: clock.
- `rst` input 1: reset. Synchronous, active-high, one clock domain.
- `int` input 6: hardware interrupt lines, level-sensitive.
- `exc_valid` input 1: exception commit strobe, one cycle per exception.
- `Exc_BadVaddr` input 32: faulting address.
- `Exc_EPC` input 32: restart PC, already BD-adjusted upstream.
- `Exc_Cause` input 6: [5] = BD, [4:0] = ExcCode.
- `eret` input 1: `eret` commit strobe.
- `mtc0_we` input 1: CP0 write enable.
- `cp0_waddr` input 5: write register number.
- `cp0_wdata` input 32: write data.
- `cp0_raddr` input 5: read register number.
- `cp0_rdata` output 32: combinational read of the current register value; 0 for unimplemented numbers.
- `int_req` output 1: interrupt pending and enabled.
- `redirect_valid` output 1: flush plus fetch redirect, combinational.
- `redirect_pc` output 32: `EXC_VECTOR` on exception, EPC on `eret`.
- `status_exl` output 1: Status.EXL.

## Operation
- Implemented registers:
  - BadVAddr (8)
  - Count (9)
  - Compare (11)
  - Status (12)
  - Cause (13)
  - EPC (14)
- Reset values: Status = 32'h0040_0000 (BEV = 1). BadVAddr, Count, Compare, Cause and EPC are all 0. The internal tick flop is 0.
- Outputs right after reset: `int_req` = 0, `redirect_valid` = 0, `status_exl` = 0.
- Status writable fields: IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1. All other bits read 0.
- Cause fields:
  - IP[9:8] (software interrupts) is writable by `mtc0`.
  - IP[15:10] is reloaded every cycle from {`int[5]` | TI, `int[4:0]`}.
  - TI[30], BD[31] and ExcCode[6:2] are written only by hardware.
- EPC, Count and Compare are fully writable. BadVAddr is read-only.
- Exception (`exc_valid`):
  - ExcCode ← `Exc_Cause[4:0]`.
  - If EXL = 0: EPC ← `Exc_EPC`, BD ← `Exc_Cause[5]`. If EXL = 1: EPC and BD are left unchanged.
  - EXL ← 1.
  - If ExcCode is 4 (AdEL) or 5 (AdES): BadVAddr ← `Exc_BadVaddr`.
  - Same cycle: `redirect_valid` = 1, `redirect_pc` = `EXC_VECTOR`.
- `eret`: EXL ← 0. Same cycle: `redirect_valid` = 1, `redirect_pc` = current EPC.
- Priority when events coincide in one cycle: `exc_valid` > `eret` > `mtc0_we`.
  - The lower-priority event is dropped entirely, except an `mtc0` to Count or Compare. Those are timer writes and still take effect.
- `int_req` = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from registered state.

## Timing
- All register updates land on the `clk` edge after the strobe. `cp0_rdata` shows the new value in the following cycle; there is no write-to-read bypass.
- `redirect_valid`/`redirect_pc` are combinational from the strobe: zero latency.
- Interrupt path: `int` sampled at edge N → Cause.IP visible in cycle N+1 → `int_req` high in cycle N+1 if enabled.
- `rst` asserted mid-operation restores every reset value on the next edge. A strobe in a reset cycle is ignored.

## Configuration
- `CP0_TIMER_EN` defined:
  - The tick flop toggles every cycle, and Count increments by 1 on cycles where tick = 1. The first increment lands at the edge ending cycle 2 after reset.
  - Count wraps from 32'hFFFF_FFFF to 0.
  - An `mtc0` to Count loads `cp0_wdata` and overrides the increment. The tick is not affected.
  - TI is set on the edge where Count is incremented to a value equal to Compare. Equality produced by a reset or by a write never sets TI.
  - An `mtc0` to Compare clears TI, and this clear wins over a same-cycle set.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0 and ignore writes.
  - TI is constant 0, so IP[15] = `int[5]` only.

## Test plan
- Reset check: release `rst` and read registers 12, 13, 14 → 32'h0040_0000, 0, 0. `int_req` = 0.
- Exception latch: `exc_valid` with `Exc_Cause` = 6'b1_00100, `Exc_EPC` = 32'hBFC0_0100, `Exc_BadVaddr` = 32'h0000_1002.
  - Same cycle: `redirect_pc` = 32'hBFC0_0380.
  - Next cycle: Cause = 32'h8000_0010, EPC = 32'hBFC0_0100, BadVAddr = 32'h0000_1002, `status_exl` = 1.
- Nested exception: while EXL = 1, `exc_valid` with ExcCode 8 and `Exc_EPC` = 32'h100 → EPC unchanged, ExcCode = 8. Then `eret` → `redirect_pc` = old EPC, EXL = 0.
- Interrupt masking: write Status = 32'h0000_0401 and drive `int[0]` = 1 → `int_req` = 1 one cycle later. Write IM = 0 → `int_req` = 0.
- Timer (`CP0_TIMER_EN`): write Compare = 5 and Count = 0 → TI and `int_req` go high (IE = 1, IM[7] = 1) about 10 cycles later. Write Compare = 5 again → TI = 0.
- Collision: `exc_valid`, `eret` and `mtc0_we` to EPC (32'hDEAD_0000) in the same cycle → EPC = `Exc_EPC`, EXL = 1, `redirect_pc` = `EXC_VECTOR`.

Source files
------------

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit -- Coprocessor-0 register block for the 5-stage MIPS pipeline.
//
// Latches the execute-stage exception record into BadVAddr/EPC/Cause/Status,
// raises the fetch redirect for exceptions and eret, serves mfc0/mtc0, samples
// the hardware interrupt lines and drives the pending-interrupt request.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   -> Count/Compare timer with TI (Cause[30]) folded into IP[15]
//   undefined -> Count/Compare read 0, ignore writes, TI constant 0
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   int_i[5:0]          hardware interrupt lines, level-sensitive
//                       (named int_i because "int" is a reserved word)
//   exc_valid           exception commit strobe
//   Exc_BadVaddr        faulting address
//   Exc_EPC             restart PC (already BD-adjusted)
//   Exc_Cause[5:0]      [5] BD, [4:0] ExcCode
//   eret                eret commit strobe
//   mtc0_we, cp0_waddr, cp0_wdata   CP0 register write
//   cp0_raddr, cp0_rdata            CP0 register read (combinational)
//   int_req             interrupt pending and enabled
//   redirect_valid, redirect_pc     flush + fetch redirect (combinational)
//   status_exl          Status.EXL
// -----------------------------------------------------------------------------
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        exc_valid,
    input  logic [31:0] Exc_BadVaddr,
    input  logic [31:0] Exc_EPC,
    input  logic [5:0]  Exc_Cause,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        int_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        status_exl
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Architectural state, kept as individual fields
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;

    // Timer view shared with the read mux and IP[15]
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ti_s;

    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic        is_addr_exc_s;

    assign status_s = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_s  = {bd_q, ti_s, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'd0};
    assign is_addr_exc_s = (Exc_Cause[4:0] == 5'd4) || (Exc_Cause[4:0] == 5'd5);

    // Next-state for Status/Cause/EPC/BadVAddr; exception beats eret beats mtc0
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        ip_sw_d   = ip_sw_q;
        epc_d     = epc_q;
        badva_d   = badva_q;
        ip_hw_d   = {int_i[5] | ti_s, int_i[4:0]};
        if (exc_valid) begin
            exccode_d = Exc_Cause[4:0];
            exl_d     = 1'b1;
            // A nested exception keeps the original restart point
            if (!exl_q) begin
                epc_d = Exc_EPC;
                bd_d  = Exc_Cause[5];
            end else begin
                epc_d = epc_q;
            end
            if (is_addr_exc_s) begin
                badva_d = Exc_BadVaddr;
            end else begin
                badva_d = badva_q;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (mtc0_we) begin
            case (cp0_waddr)
                REG_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                REG_CAUSE: ip_sw_d = cp0_wdata[9:8];
                REG_EPC:   epc_d   = cp0_wdata;
                default:   ip_sw_d = ip_sw_q;
            endcase
        end else begin
            ip_sw_d = ip_sw_q;
        end
    end

    // Status/Cause/EPC/BadVAddr registers
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q      <= 8'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            exccode_q <= 5'd0;
            ip_sw_q   <= 2'd0;
            ip_hw_q   <= 6'd0;
            epc_q     <= 32'd0;
            badva_q   <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            exccode_q <= exccode_d;
            ip_sw_q   <= ip_sw_d;
            ip_hw_q   <= ip_hw_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick_q;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic [31:0] count_inc_s;

    assign count_inc_s = count_q + 32'd1;

    // Timer next-state; timer writes are never dropped by exception/eret
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (mtc0_we && (cp0_waddr == REG_COUNT)) begin
            count_d = cp0_wdata;
        end else if (tick_q) begin
            count_d = count_inc_s;
            // Only an increment landing on Compare raises TI
            if (count_inc_s == compare_q) begin
                ti_d = 1'b1;
            end else begin
                ti_d = ti_q;
            end
        end else begin
            count_d = count_q;
        end
        // Compare write clears TI and wins over a same-cycle set
        if (mtc0_we && (cp0_waddr == REG_COMPARE)) begin
            compare_d = cp0_wdata;
            ti_d      = 1'b0;
        end else begin
            compare_d = compare_q;
        end
    end

    // Timer registers; tick halves the Count rate
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= ~tick_q;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_s   = count_q;
    assign compare_s = compare_q;
    assign ti_s      = ti_q;
`else
    assign count_s   = 32'd0;
    assign compare_s = 32'd0;
    assign ti_s      = 1'b0;
`endif

    // Read mux, no write-to-read bypass
    always_comb begin
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badva_q;
            REG_COUNT:    cp0_rdata = count_s;
            REG_COMPARE:  cp0_rdata = compare_s;
            REG_STATUS:   cp0_rdata = status_s;
            REG_CAUSE:    cp0_rdata = cause_s;
            REG_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    // Strobes in a reset cycle are ignored, including their redirect
    assign redirect_valid = ~rst & (exc_valid | eret);
    assign redirect_pc    = exc_valid ? EXC_VECTOR : epc_q;
    assign int_req        = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
    assign status_exl     = exl_q;

endmodule
